riscv_id_regfile: RTL and testbench
===================================

# riscv_id_regfile

Parametrised instruction-decode stage with integrated register file for the RISC-V datapath. It extracts register indices and function fields from a 32-bit instruction and reads two source operands with same-cycle writeback bypass. Results are registered into an ID/EX pipeline register with valid, stall and flush control. It sits between instruction fetch and the ALU/execute stage and accepts the writeback port from the last pipeline stage.

## Interface
Parameters:
- XLEN, 64, data width of each register and of all data ports
- NREGS, 32, number of architectural registers; a power of two from 2 to 32; the index width is AW = clog2(NREGS)
- BYPASS, 1, 1 enables writeback-to-read forwarding; 0 means reads return the stored value only
- ZERO_REG, 1, 1 makes register 0 read as zero and ignore writes

Ports:
- clk, input, 1, single clock; all state updates on the rising edge
- reset, input, 1, asynchronous, active-high; clears all state
- instruction, input, 32, instruction to decode
- in_valid, input, 1, the instruction is valid this cycle
- stall, input, 1, hold the ID/EX register contents
- flush, input, 1, invalidate the ID/EX register
- RegWrite, input, 1, writeback enable
- wb_rd, input, AW, writeback destination index
- WriteData, input, XLEN, writeback data
- ReadData1, output, XLEN, registered rs1 operand
- ReadData2, output, XLEN, registered rs2 operand
- rd_out, output, AW, registered destination index
- opcode_out, output, 7, registered opcode
- funct3_out, output, 3, registered funct3
- funct7_out, output, 7, registered funct7
- out_valid, output, 1, the ID/EX register holds a valid instruction

## Operation
- Field decode:
  - rs1 = instruction[19:15], rs2 = instruction[24:20], rd = instruction[11:7]
  - opcode = instruction[6:0], funct3 = instruction[14:12], funct7 = instruction[31:25]
  - Each index is truncated to its low AW bits.
- Register write: when RegWrite=1, register wb_rd takes WriteData at the clock edge.
  - When ZERO_REG=1 and wb_rd=0, the write is dropped.
- Combinational read:
  - When ZERO_REG=1 and the index is 0, the result is 0.
  - Otherwise, when BYPASS=1, RegWrite=1 and wb_rd equals the index, the result is WriteData.
  - Otherwise, the result is the stored value.
- ID/EX register update, in priority order:
  - reset: all fields are 0 and out_valid=0.
  - flush=1: out_valid goes to 0 and the data fields hold. Flush beats stall.
  - stall=1: all fields hold. A RegWrite in the same cycle still updates the register file.
  - Otherwise: all fields load from the decode and read results, and out_valid takes in_valid.
- When in_valid=0 and the register is neither stalled nor flushed, fields still load and out_valid=0.
- Stall hazard: a stalled entry keeps its old operands even if the source register is written during the stall.
  - Re-reading after a stall is the hazard unit's job; this block does not re-read.

## Timing
- Read-to-output latency is 1 cycle: the instruction presented in cycle N appears on the outputs after edge N+1.
- A write takes effect at the edge. With BYPASS=0, a read of the same register in the same cycle returns the old value.
- Reset is asynchronous. While reset is held, every output reads 0 and every register file entry reads 0.
- Deasserting reset mid-operation loses every in-flight instruction. The first load happens on the first edge with reset low.
- The register file holds its contents across stall and flush; only reset clears it.

## Structure
- Shared package riscv_pkg holds:
  - the instruction field bit positions
  - opcode constants: OP_RTYPE = 7'b0110011, OP_ITYPE = 7'b0010011, OP_LOAD = 7'b0000011
  - an idex_t struct bundling the registered fields
- One sub-module, riscv_regfile, contains the storage array, the write port, both read ports with bypass, and the zero-register logic, using the same parameters.
- The top level contains the field decode and the ID/EX register only.

## Test plan
- Reset: hold reset high and drive instruction 32'h01548133.
  - All outputs must read 0 and out_valid=0.
  - Release reset, then apply in_valid=1. After 1 edge, rd_out=2, opcode_out=7'h33, funct3_out=0, funct7_out=0, ReadData1=0, ReadData2=0.
- Write, then read: write x9=64'h2AD5C7 and x21=64'h5. Then issue 32'h01548133.
  - After the next edge, ReadData1=64'h2AD5C7 and ReadData2=64'h5.
- Bypass: in the same cycle, drive RegWrite=1, wb_rd=9 and WriteData=64'hDEAD with the same instruction.
  - With BYPASS=1, ReadData1=64'hDEAD at the next edge.
  - With BYPASS=0, ReadData1 holds the old x9 value.
- Zero register: write wb_rd=0 with 64'hFFFF, then read rs1=0.
  - ReadData1=0 with ZERO_REG=1.
  - ReadData1=64'hFFFF with ZERO_REG=0.
- Stall and flush:
  - Assert stall for 3 cycles with new instructions driven: the outputs must not change.
  - Assert stall and flush together: out_valid=0 after the next edge.
- Asynchronous reset mid-stream: pulse reset between clock edges while out_valid=1.
  - Outputs must go to 0 immediately, with no edge.
  - Register file reads must return 0 afterwards.
  - Run with NREGS=16, XLEN=32 as well.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V decode stage: instruction field
// positions, major opcodes and the ID/EX control bundle.
package riscv_pkg;

    // Instruction field bit positions
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    // Widest register index an instruction can carry
    localparam int REG_IDX_W = RD_MSB - RD_LSB + 1;

    // Major opcodes
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    // Decoded fields carried in the ID/EX register alongside the operands
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [6:0]           opcode;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
    } idex_t;

endpackage

// File: rtl/riscv_regfile.sv
// Architectural register file: one write port, two combinational read
// ports with optional writeback forwarding and optional hard-wired zero.
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] i_rs1,
    input  logic [$clog2(NREGS)-1:0] i_rs2,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_wb_rd,
    input  logic [XLEN-1:0]          i_wdata,
    output logic [XLEN-1:0]          o_rdata1,
    output logic [XLEN-1:0]          o_rdata2
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_en;

    // Writes to x0 are discarded when it is hard-wired to zero
    assign w_wr_en = i_we && !((ZERO_REG != 0) && (i_wb_rd == '0));

    // Resolve one read: zero register first, then forwarding, then storage
    function automatic logic [XLEN-1:0] f_read(
        input logic [AW-1:0]   idx,
        input logic [XLEN-1:0] stored
    );
        if ((ZERO_REG != 0) && (idx == '0))
            return '0;
        else if ((BYPASS != 0) && i_we && (i_wb_rd == idx))
            return i_wdata;
        else
            return stored;
    endfunction

    // Storage array with a single write port
    // NOTE: the array is reset because a reset must leave every register
    // reading zero; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[i_wb_rd] <= i_wdata;
        end
    end

    // Both read ports, resolved combinationally in the decode cycle
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        o_rdata1 = f_read(i_rs1, r_regs[i_rs1]);
        o_rdata2 = f_read(i_rs2, r_regs[i_rs2]);
    end

endmodule

// File: rtl/riscv_id_regfile.sv
// Instruction-decode stage: splits the instruction into fields, reads two
// operands from the register file and registers everything into ID/EX.
module riscv_id_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instruction,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     RegWrite,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic [XLEN-1:0]          WriteData,
    output logic [XLEN-1:0]          ReadData1,
    output logic [XLEN-1:0]          ReadData2,
    output logic [$clog2(NREGS)-1:0] rd_out,
    output logic [6:0]               opcode_out,
    output logic [2:0]               funct3_out,
    output logic [6:0]               funct7_out,
    output logic                     out_valid
);

    localparam int AW = $clog2(NREGS);

    logic [REG_IDX_W-1:0] w_rs1_full;
    logic [REG_IDX_W-1:0] w_rs2_full;
    logic [AW-1:0]        w_rs1;
    logic [AW-1:0]        w_rs2;
    logic [XLEN-1:0]      w_rdata1;
    logic [XLEN-1:0]      w_rdata2;
    idex_t                w_dec;

    idex_t                r_idex;
    logic [XLEN-1:0]      r_rdata1;
    logic [XLEN-1:0]      r_rdata2;

    // Source indices, truncated to the register file's index width
    assign w_rs1_full = instruction[RS1_MSB:RS1_LSB];
    assign w_rs2_full = instruction[RS2_MSB:RS2_LSB];
    assign w_rs1      = w_rs1_full[AW-1:0];
    assign w_rs2      = w_rs2_full[AW-1:0];

    // Field decode of the incoming instruction
    always_comb begin
        w_dec        = '0;
        w_dec.valid  = in_valid;
        w_dec.rd     = instruction[RD_MSB:RD_LSB];
        w_dec.opcode = instruction[OPCODE_MSB:OPCODE_LSB];
        w_dec.funct3 = instruction[FUNCT3_MSB:FUNCT3_LSB];
        w_dec.funct7 = instruction[FUNCT7_MSB:FUNCT7_LSB];
    end

    riscv_regfile #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .i_rs1    (w_rs1),
        .i_rs2    (w_rs2),
        .i_we     (RegWrite),
        .i_wb_rd  (wb_rd),
        .i_wdata  (WriteData),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    // ID/EX register: flush drops valid but keeps data, stall holds all
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idex   <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else if (flush) begin
            r_idex.valid <= 1'b0;
        end else if (!stall) begin
            r_idex   <= w_dec;
            r_rdata1 <= w_rdata1;
            r_rdata2 <= w_rdata2;
        end
    end

    assign ReadData1  = r_rdata1;
    assign ReadData2  = r_rdata2;
    assign rd_out     = r_idex.rd[AW-1:0];
    assign opcode_out = r_idex.opcode;
    assign funct3_out = r_idex.funct3;
    assign funct7_out = r_idex.funct7;
    assign out_valid  = r_idex.valid;

endmodule

// File: tb/tb_riscv_id_regfile.sv
// Self-checking bench for riscv_id_regfile. Three configurations share the
// same stimulus: defaults (a), no bypass / no zero register (b) and a
// 16 x 32-bit file (c). Each is checked against an array-based model.
module tb_riscv_id_regfile;

    localparam int NI = 3;
    localparam int P_BYP  [NI] = '{1, 0, 1};
    localparam int P_ZERO [NI] = '{1, 0, 1};
    localparam int P_AW   [NI] = '{5, 5, 4};
    localparam int P_XW   [NI] = '{64, 64, 32};

    localparam logic [31:0] INSTR_MAIN  = 32'h01548133;  // add x2, x9, x21
    localparam logic [31:0] INSTR_RS1_0 = 32'h015001B3;  // add x3, x0, x21

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        in_valid, stall, flush, RegWrite;
    logic [4:0]  wb_rd;
    logic [63:0] WriteData;

    logic [63:0] a_d1, a_d2, b_d1, b_d2;
    logic [31:0] c_d1, c_d2;
    logic [4:0]  a_rd, b_rd;
    logic [3:0]  c_rd;
    logic [6:0]  a_op, b_op, c_op, a_f7, b_f7, c_f7;
    logic [2:0]  a_f3, b_f3, c_f3;
    logic        a_v, b_v, c_v;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_id_regfile dut_a (
        .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
        .stall(stall), .flush(flush), .RegWrite(RegWrite), .wb_rd(wb_rd),
        .WriteData(WriteData), .ReadData1(a_d1), .ReadData2(a_d2), .rd_out(a_rd),
        .opcode_out(a_op), .funct3_out(a_f3), .funct7_out(a_f7), .out_valid(a_v)
    );

    riscv_id_regfile #(.BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
        .stall(stall), .flush(flush), .RegWrite(RegWrite), .wb_rd(wb_rd),
        .WriteData(WriteData), .ReadData1(b_d1), .ReadData2(b_d2), .rd_out(b_rd),
        .opcode_out(b_op), .funct3_out(b_f3), .funct7_out(b_f7), .out_valid(b_v)
    );

    riscv_id_regfile #(.XLEN(32), .NREGS(16)) dut_c (
        .clk(clk), .reset(reset), .instruction(instruction), .in_valid(in_valid),
        .stall(stall), .flush(flush), .RegWrite(RegWrite), .wb_rd(wb_rd[3:0]),
        .WriteData(WriteData[31:0]), .ReadData1(c_d1), .ReadData2(c_d2), .rd_out(c_rd),
        .opcode_out(c_op), .funct3_out(c_f3), .funct7_out(c_f7), .out_valid(c_v)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        v;
    } out_t;

    logic [63:0] m_regs [NI][32];
    out_t        e [NI];

    function automatic int nregs(input int k);
        return 1 << P_AW[k];
    endfunction

    function automatic logic [63:0] xmask(input int k);
        if (P_XW[k] == 64) return '1;
        return (64'd1 << P_XW[k]) - 64'd1;
    endfunction

    // Value an instruction reading register idx sees this cycle
    function automatic logic [63:0] m_read(input int k, input int idx);
        if (P_ZERO[k] != 0 && idx == 0) return 64'd0;
        if (P_BYP[k] != 0 && RegWrite && (int'(wb_rd) % nregs(k)) == idx)
            return WriteData & xmask(k);
        return m_regs[k][idx];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < 32; r++) m_regs[k][r] = 64'd0;
            e[k] = '{64'd0, 64'd0, 5'd0, 7'd0, 3'd0, 7'd0, 1'b0};
        end
    endtask

    // Expected ID/EX contents after the coming edge
    task automatic model_predict();
        for (int k = 0; k < NI; k++) begin
            if (flush) begin
                e[k].v = 1'b0;
            end else if (!stall) begin
                e[k].d1 = m_read(k, int'(instruction[19:15]) % nregs(k));
                e[k].d2 = m_read(k, int'(instruction[24:20]) % nregs(k));
                e[k].rd = 5'(int'(instruction[11:7]) % nregs(k));
                e[k].op = instruction[6:0];
                e[k].f3 = instruction[14:12];
                e[k].f7 = instruction[31:25];
                e[k].v  = in_valid;
            end
        end
    endtask

    task automatic model_write();
        int w;
        for (int k = 0; k < NI; k++) begin
            w = int'(wb_rd) % nregs(k);
            if (RegWrite && !(P_ZERO[k] != 0 && w == 0))
                m_regs[k][w] = WriteData & xmask(k);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic out_t observe(input int k);
        out_t o;
        case (k)
            0: o = '{a_d1, a_d2, a_rd, a_op, a_f3, a_f7, a_v};
            1: o = '{b_d1, b_d2, b_rd, b_op, b_f3, b_f7, b_v};
            default: o = '{{32'd0, c_d1}, {32'd0, c_d2}, {1'b0, c_rd}, c_op, c_f3, c_f7, c_v};
        endcase
        return o;
    endfunction

    task automatic compare_all(input string tag);
        out_t o;
        for (int k = 0; k < NI; k++) begin
            o = observe(k);
            check($sformatf("%s[%0d].ReadData1", tag, k), o.d1, e[k].d1);
            check($sformatf("%s[%0d].ReadData2", tag, k), o.d2, e[k].d2);
            check($sformatf("%s[%0d].rd_out", tag, k), 64'(o.rd), 64'(e[k].rd));
            check($sformatf("%s[%0d].opcode_out", tag, k), 64'(o.op), 64'(e[k].op));
            check($sformatf("%s[%0d].funct3_out", tag, k), 64'(o.f3), 64'(e[k].f3));
            check($sformatf("%s[%0d].funct7_out", tag, k), 64'(o.f7), 64'(e[k].f7));
            check($sformatf("%s[%0d].out_valid", tag, k), 64'(o.v), 64'(e[k].v));
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic iv, input logic st,
                         input logic fl, input logic we, input logic [4:0] wr,
                         input logic [63:0] wd);
        instruction = ins;
        in_valid    = iv;
        stall       = st;
        flush       = fl;
        RegWrite    = we;
        wb_rd       = wr;
        WriteData   = wd;
    endtask

    // One clock: predict, advance, then compare 1 time unit after the edge
    task automatic cycle(input string tag);
        model_predict();
        model_write();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b1;
        drive(INSTR_MAIN, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset_held");

        // First instruction after reset release
        reset = 1'b0;
        cycle("first_load");
        check("first_load.rd_out", 64'(a_rd), 64'd2);
        check("first_load.opcode_out", 64'(a_op), 64'h33);
        check("first_load.ReadData1", a_d1, 64'd0);

        // Write x9 and x21, then read them back
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 64'h2AD5C7);
        cycle("wr_x9");
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd21, 64'h5);
        cycle("wr_x21");
        drive(INSTR_MAIN, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        cycle("readback");
        check("readback.ReadData1", a_d1, 64'h2AD5C7);
        check("readback.ReadData2", a_d2, 64'h5);

        // Same-cycle writeback to rs1
        drive(INSTR_MAIN, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 64'hDEAD);
        cycle("bypass");
        check("bypass.on.ReadData1", a_d1, 64'hDEAD);
        check("bypass.off.ReadData1", b_d1, 64'h2AD5C7);

        // Writes to x0
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 64'hFFFF);
        cycle("wr_x0");
        drive(INSTR_RS1_0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        cycle("read_x0");
        check("zero_on.ReadData1", a_d1, 64'd0);
        check("zero_off.ReadData1", b_d1, 64'hFFFF);

        // Stall three cycles with new instructions and writes to the held rs1
        drive(INSTR_MAIN, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        cycle("pre_stall");
        for (int i = 0; i < 3; i++) begin
            drive($urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1, 5'd9,
                  {$urandom, $urandom});
            cycle("stall");
            check("stall.ReadData1", a_d1, 64'hDEAD);
            check("stall.out_valid", 64'(a_v), 64'd1);
        end
        drive($urandom, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0);
        cycle("stall_flush");
        check("stall_flush.out_valid", 64'(a_v), 64'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) wb_rd = instruction[19:15];
            cycle("random");
        end

        // Asynchronous reset between edges while holding a valid entry
        drive(INSTR_MAIN, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        cycle("pre_async");
        check("pre_async.out_valid", 64'(a_v), 64'd1);
        reset = 1'b1;
        #2;
        model_reset();
        compare_all("async_reset");
        #1;
        reset = 1'b0;
        drive(INSTR_MAIN, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
        cycle("post_reset");
        check("post_reset.ReadData1", a_d1, 64'd0);
        check("post_reset.ReadData2", a_d2, 64'd0);
        check("post_reset.small.ReadData1", 64'(c_d1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
